// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write arbiter.
//   REG_AW    : register address width (x0..x31)
//   DATA_W    : register data width
//   NUM_REGS  : number of architectural registers
//   req_e     : requester index encoding (ALU = 0, MEM = 1)
package regfile_write_arbiter_pkg;

    localparam int REG_AW   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_AW;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    // x0 is hardwired to zero: writes to it are dropped, it is never pending.
    function automatic logic is_x0(input reg_addr_t addr);
        return addr == '0;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Handshake/bus bundle between the writeback requesters, decode and the
// register-file write arbiter.
//   alu_valid/alu_rd/alu_wd/alu_ready : ALU writeback request channel
//   mem_valid/mem_rd/mem_wd/mem_ready : load/multi-cycle writeback channel
//   rsv_en/rsv_rd                     : reserve destination of an issued op
//   chk_rs1/chk_rs2/hazard            : decode-stage source check
//   rf_A3/rf_WD3/rf_WE3               : registered register-file write port
// master = requester/decode side, slave = arbiter.
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic      alu_valid;
    reg_addr_t alu_rd;
    reg_data_t alu_wd;
    logic      alu_ready;

    logic      mem_valid;
    reg_addr_t mem_rd;
    reg_data_t mem_wd;
    logic      mem_ready;

    logic      rsv_en;
    reg_addr_t rsv_rd;

    reg_addr_t chk_rs1;
    reg_addr_t chk_rs2;
    logic      hazard;

    reg_addr_t rf_A3;
    reg_data_t rf_WD3;
    logic      rf_WE3;

    modport master (
        output alu_valid, alu_rd, alu_wd,
        input  alu_ready,
        output mem_valid, mem_rd, mem_wd,
        input  mem_ready,
        output rsv_en, rsv_rd, chk_rs1, chk_rs2,
        input  hazard, rf_A3, rf_WD3, rf_WE3
    );

    modport slave (
        input  alu_valid, alu_rd, alu_wd,
        output alu_ready,
        input  mem_valid, mem_rd, mem_wd,
        output mem_ready,
        input  rsv_en, rsv_rd, chk_rs1, chk_rs2,
        output hazard, rf_A3, rf_WD3, rf_WE3
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register x1..x31 (x0 never pending).
//   clk, rst          : clock, synchronous active-low reset
//   set_en, set_rd    : mark a register as awaiting writeback
//   clr_en, clr_rd    : writeback granted, register no longer pending
//   chk_rs1, chk_rs2  : decode source registers
//   hazard            : either source has a pending write (0 during reset)
module regfile_scoreboard
    import regfile_write_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      set_en,
    input  reg_addr_t set_rd,
    input  logic      clr_en,
    input  reg_addr_t clr_rd,
    input  reg_addr_t chk_rs1,
    input  reg_addr_t chk_rs2,
    output logic      hazard
);

    localparam logic [NUM_REGS-1:0] X0_MASK = NUM_REGS'(1);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_rd] = 1'b1;
        if (clr_en) clr_mask[clr_rd] = 1'b1;
    end

    // Set is applied after clear so a re-reservation of the register being
    // written back keeps it pending. Bit 0 is forced low so x0 never stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~clr_mask) | set_mask) & ~X0_MASK;
        end
    end

    // The clear lands on the edge that loads the write port, so in the
    // commit cycle the bit is already low (register file writes on negedge).
    assign hazard = rst & (pending[chk_rs1] | pending[chk_rs2]);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with round-robin fairness,
// registered write port and pending-write scoreboard for decode stalls.
//   clk  : system clock, rising-edge state updates
//   rst  : synchronous active-low reset
//   bus  : regfile_write_arbiter_if.slave (request channels, reservation,
//          hazard check and registered rf_A3/rf_WD3/rf_WE3 write port)
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    regfile_write_arbiter_if.slave  bus
);

    req_e      last_grant;
    logic      grant_alu;
    logic      grant_mem;
    logic      grant_any;
    reg_addr_t grant_rd;
    reg_data_t grant_wd;

    reg_addr_t a3_q;
    reg_data_t wd3_q;
    logic      we3_q;

    // A lone valid wins outright; on contention the side not granted most
    // recently wins. Nothing is granted while reset is held.
    always_comb begin
        grant_alu = 1'b0;
        grant_mem = 1'b0;
        if (rst) begin
            if (bus.alu_valid && bus.mem_valid) begin
                grant_mem = (last_grant == REQ_ALU);
                grant_alu = (last_grant == REQ_MEM);
            end else begin
                grant_alu = bus.alu_valid;
                grant_mem = bus.mem_valid;
            end
        end
        grant_any = grant_alu | grant_mem;
        grant_rd  = grant_mem ? bus.mem_rd : bus.alu_rd;
        grant_wd  = grant_mem ? bus.mem_wd : bus.alu_wd;
    end

    assign bus.alu_ready = grant_alu;
    assign bus.mem_ready = grant_mem;

    // last_grant resets to ALU so MEM wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= REQ_ALU;
            we3_q      <= 1'b0;
            a3_q       <= '0;
            wd3_q      <= '0;
        end else begin
            we3_q <= grant_any && !is_x0(grant_rd);
            if (grant_any) begin
                last_grant <= grant_mem ? REQ_MEM : REQ_ALU;
            end
            if (grant_any && !is_x0(grant_rd)) begin
                a3_q  <= grant_rd;
                wd3_q <= grant_wd;
            end
        end
    end

    assign bus.rf_A3  = a3_q;
    assign bus.rf_WD3 = wd3_q;
    assign bus.rf_WE3 = we3_q;

    regfile_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .set_en  (bus.rsv_en),
        .set_rd  (bus.rsv_rd),
        .clr_en  (grant_any),
        .clr_rd  (grant_rd),
        .chk_rs1 (bus.chk_rs1),
        .chk_rs2 (bus.chk_rs2),
        .hazard  (bus.hazard)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter: directed scenarios plus a
// randomized run compared against a behavioural model of the arbiter rules.
module tb_regfile_write_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // ---------------- behavioural model ----------------
    bit          m_pend[32];     // register awaiting writeback
    int          m_last;         // 0 = ALU granted last, 1 = MEM granted last
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    bit          m_known;        // rf_A3/rf_WD3 defined (not after an x0 grant)

    function automatic void model_grant(output bit ga, output bit gm);
        ga = 0;
        gm = 0;
        if (rst) begin
            if (bus.alu_valid && bus.mem_valid) begin
                if (m_last == 0) gm = 1; else ga = 1;
            end else begin
                ga = bus.alu_valid;
                gm = bus.mem_valid;
            end
        end
    endfunction

    function automatic bit model_hazard();
        return rst && (m_pend[bus.chk_rs1] || m_pend[bus.chk_rs2]);
    endfunction

    function automatic void model_edge();
        bit ga, gm;
        logic [4:0]  rd;
        logic [31:0] wd;
        model_grant(ga, gm);
        if (!rst) begin
            foreach (m_pend[i]) m_pend[i] = 0;
            m_last = 0; m_we = 0; m_a3 = 0; m_wd = 0; m_known = 1;
            return;
        end
        m_we = 0;
        if (ga || gm) begin
            rd = gm ? bus.mem_rd : bus.alu_rd;
            wd = gm ? bus.mem_wd : bus.alu_wd;
            m_last = gm ? 1 : 0;
            if (rd != 0) begin
                m_we = 1; m_a3 = rd; m_wd = wd; m_known = 1;
                m_pend[rd] = 0;
            end else begin
                m_known = 0;
            end
        end
        if (bus.rsv_en && bus.rsv_rd != 0) m_pend[bus.rsv_rd] = 1;
    endfunction

    task automatic apply(input bit av, input logic [4:0] ard, input logic [31:0] awd,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] mwd,
                         input bit re, input logic [4:0] rrd,
                         input logic [4:0] c1, input logic [4:0] c2);
        bus.alu_valid = av; bus.alu_rd = ard; bus.alu_wd = awd;
        bus.mem_valid = mv; bus.mem_rd = mrd; bus.mem_wd = mwd;
        bus.rsv_en = re; bus.rsv_rd = rrd;
        bus.chk_rs1 = c1; bus.chk_rs2 = c2;
        #1;
    endtask

    task automatic idle();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        apply(1, 5, 32'h11, 1, 6, 32'h22, 1, 6, 6, 5);
        n_checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0)
            $display("FAIL reset_ready alu=%b mem=%b required 0/0", bus.alu_ready, bus.mem_ready);
        else n_pass++;
        n_checks++;
        if (bus.hazard !== 1'b0) $display("FAIL reset_hazard got %b required 0", bus.hazard);
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (bus.rf_WE3 !== 1'b0 || bus.rf_A3 !== 5'd0 || bus.rf_WD3 !== 32'd0)
            $display("FAIL reset_wport we=%b a3=%0d wd=%h required 0/0/0",
                     bus.rf_WE3, bus.rf_A3, bus.rf_WD3);
        else n_pass++;
        rst = 1'b1;
        for (int r = 1; r < 32; r++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 5'(r), 5'(r));
            n_checks++;
            if (bus.hazard !== 1'b0) $display("FAIL reset_pending x%0d hazard=%b required 0", r, bus.hazard);
            else n_pass++;
        end
    endtask

    task automatic test_alu_single();
        apply(1, 5, 32'h0000_00AA, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0)
            $display("FAIL alu_single_ready alu=%b mem=%b required 1/0", bus.alu_ready, bus.mem_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.rf_WE3 !== 1'b1 || bus.rf_A3 !== 5'd5 || bus.rf_WD3 !== 32'hAA)
            $display("FAIL alu_single_write we=%b a3=%0d wd=%h required 1/5/000000aa",
                     bus.rf_WE3, bus.rf_A3, bus.rf_WD3);
        else n_pass++;
        idle();
        tick();
        n_checks++;
        if (bus.rf_WE3 !== 1'b0 || bus.rf_A3 !== 5'd5 || bus.rf_WD3 !== 32'hAA)
            $display("FAIL idle_hold we=%b a3=%0d wd=%h required 0/5/000000aa",
                     bus.rf_WE3, bus.rf_A3, bus.rf_WD3);
        else n_pass++;
    endtask

    task automatic test_alternate();
        int exp_a3[4]  = '{4, 3, 4, 3};
        bit exp_mem[4] = '{1, 0, 1, 0};
        do_reset();
        idle();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 4; i++) begin
            apply(1, 3, 32'h300 + i, 1, 4, 32'h400 + i, 0, 0, 0, 0);
            n_checks++;
            if (bus.mem_ready !== exp_mem[i] || bus.alu_ready !== !exp_mem[i])
                $display("FAIL alternate_grant[%0d] mem=%b alu=%b required %b/%b",
                         i, bus.mem_ready, bus.alu_ready, exp_mem[i], !exp_mem[i]);
            else n_pass++;
            tick();
            n_checks++;
            if (bus.rf_WE3 !== 1'b1 || bus.rf_A3 !== 5'(exp_a3[i]))
                $display("FAIL alternate_a3[%0d] we=%b a3=%0d required 1/%0d",
                         i, bus.rf_WE3, bus.rf_A3, exp_a3[i]);
            else n_pass++;
        end
        idle();
    endtask

    task automatic test_reserve_hazard();
        apply(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
            n_checks++;
            if (bus.hazard !== 1'b1) $display("FAIL rsv_hazard[%0d] got %b required 1", i, bus.hazard);
            else n_pass++;
            tick();
        end
        apply(0, 0, 0, 1, 7, 32'hCAFE_0007, 0, 0, 7, 0);
        n_checks++;
        if (bus.hazard !== 1'b1 || bus.mem_ready !== 1'b1)
            $display("FAIL rsv_grant_cycle hazard=%b mem=%b required 1/1", bus.hazard, bus.mem_ready);
        else n_pass++;
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
        n_checks++;
        if (bus.hazard !== 1'b0 || bus.rf_WE3 !== 1'b1 || bus.rf_A3 !== 5'd7)
            $display("FAIL rsv_commit hazard=%b we=%b a3=%0d required 0/1/7",
                     bus.hazard, bus.rf_WE3, bus.rf_A3);
        else n_pass++;
    endtask

    task automatic test_set_wins();
        apply(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        tick();
        apply(0, 0, 0, 1, 9, 32'h9999, 1, 9, 0, 9);
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 9);
        n_checks++;
        if (bus.hazard !== 1'b1 || bus.rf_WE3 !== 1'b1 || bus.rf_A3 !== 5'd9)
            $display("FAIL set_wins hazard=%b we=%b a3=%0d required 1/1/9",
                     bus.hazard, bus.rf_WE3, bus.rf_A3);
        else n_pass++;
        apply(0, 0, 0, 1, 9, 32'h9998, 0, 0, 0, 9);
        tick();
        idle();
    endtask

    task automatic test_x0();
        apply(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (bus.alu_ready !== 1'b1) $display("FAIL x0_ready got %b required 1", bus.alu_ready);
        else n_pass++;
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.rf_WE3 !== 1'b0 || bus.hazard !== 1'b0)
            $display("FAIL x0_write we=%b hazard=%b required 0/0", bus.rf_WE3, bus.hazard);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        apply(0, 0, 0, 0, 0, 0, 1, 20, 0, 0);
        tick();
        apply(1, 12, 32'h1212, 0, 0, 0, 0, 0, 20, 0);
        tick();
        rst = 1'b0;
        apply(1, 13, 32'h1313, 1, 14, 32'h1414, 0, 0, 20, 0);
        n_checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0 || bus.hazard !== 1'b0)
            $display("FAIL midreset_comb alu=%b mem=%b hazard=%b required 0/0/0",
                     bus.alu_ready, bus.mem_ready, bus.hazard);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.rf_WE3 !== 1'b0 || bus.rf_A3 !== 5'd0)
            $display("FAIL midreset_wport we=%b a3=%0d required 0/0", bus.rf_WE3, bus.rf_A3);
        else n_pass++;
        rst = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 0, 0, 20, 12);
        n_checks++;
        if (bus.hazard !== 1'b0) $display("FAIL midreset_pending hazard=%b required 0", bus.hazard);
        else n_pass++;
    endtask

    task automatic test_random();
        bit ga, gm;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) != 0);
            apply($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            model_grant(ga, gm);
            n_checks++;
            if (bus.alu_ready !== ga || bus.mem_ready !== gm)
                $display("FAIL rand_ready[%0d] alu=%b mem=%b required %b/%b",
                         i, bus.alu_ready, bus.mem_ready, ga, gm);
            else n_pass++;
            n_checks++;
            if (bus.hazard !== model_hazard())
                $display("FAIL rand_hazard[%0d] got %b required %b", i, bus.hazard, model_hazard());
            else n_pass++;
            tick();
            n_checks++;
            if (bus.rf_WE3 !== m_we)
                $display("FAIL rand_we[%0d] got %b required %b", i, bus.rf_WE3, m_we);
            else n_pass++;
            if (m_known) begin
                n_checks++;
                if (bus.rf_A3 !== m_a3 || bus.rf_WD3 !== m_wd)
                    $display("FAIL rand_wport[%0d] a3=%0d wd=%h required %0d/%h",
                             i, bus.rf_A3, bus.rf_WD3, m_a3, m_wd);
                else n_pass++;
            end
        end
        rst = 1'b1;
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_single();
        test_alternate();
        test_reserve_hazard();
        test_set_wins();
        test_x0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
